// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: gathers PAYLOAD_BYTES bytes plus a trailing CRC byte,
// publishes the payload only when the CRC matches, and keeps saturating frame/error counts.
module crc8_frame_checker #(
    parameter int          PAYLOAD_BYTES = 8,
    parameter logic [7:0]  POLYNOMIAL    = 8'h07,
    parameter logic [7:0]  INITIAL       = 8'hFF,
    parameter logic [15:0] TIMEOUT       = 16'd1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_valid,
    input  logic                       rx_sof,
    input  logic [7:0]                 rx_data,
    output logic [8*PAYLOAD_BYTES-1:0] payload_o,
    output logic                       frame_ok,
    output logic                       crc_err,
    output logic                       sync_err,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic [15:0]                err_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CRC     = 2'd2
    } state_t;

    localparam logic [3:0] LAST_INDEX  = 4'(PAYLOAD_BYTES - 1);
    // A one-byte payload is complete as soon as its sof byte lands.
    localparam state_t     START_STATE = (PAYLOAD_BYTES == 1) ? S_CRC : S_PAYLOAD;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_crc;
    logic [3:0]  r_index;
    logic [15:0] r_tcnt;
    logic        r_frame_ok;
    logic        r_crc_err;
    logic        r_sync_err;
    logic [15:0] r_frame_count;
    logic [15:0] r_err_count;

    logic        w_timeout;
    logic        w_start;
    logic        w_store;
    logic        w_check;
    logic        w_match;
    logic        w_sof_abort;
    logic        w_any_err;
    logic [7:0]  w_crc_base;
    logic [7:0]  w_crc_stepped;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ POLYNOMIAL) : (x << 1);
        end
        return x;
    endfunction

    assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_tcnt == TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && rx_sof) begin
                    w_state_next = START_STATE;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (rx_sof) begin
                        w_state_next = START_STATE;
                    end else if (r_index == LAST_INDEX) begin
                        w_state_next = S_CRC;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_CRC: begin
                if (rx_valid || w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start     = 1'b0;
        w_store     = 1'b0;
        w_check     = 1'b0;
        w_sof_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = rx_valid && rx_sof;
            end
            S_PAYLOAD: begin
                w_start     = rx_valid && rx_sof;
                w_sof_abort = rx_valid && rx_sof;
                w_store     = rx_valid && !rx_sof;
            end
            S_CRC: begin
                w_check = rx_valid;
            end
            default: begin
            end
        endcase
    end

    assign w_match       = w_check && (rx_data == r_crc);
    assign w_any_err     = (w_check && !w_match) || w_sof_abort || w_timeout;
    // A restart seeds from INITIAL even when an aborted frame left a partial CRC behind.
    assign w_crc_base    = w_start ? INITIAL : r_crc;
    assign w_crc_stepped = crc_step(w_crc_base, rx_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crc         <= INITIAL;
            r_index       <= 4'd0;
            r_tcnt        <= 16'd0;
            r_frame_ok    <= 1'b0;
            r_crc_err     <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_count <= 16'd0;
            r_err_count   <= 16'd0;
        end else begin
            r_frame_ok <= w_match;
            r_crc_err  <= w_check && !w_match;
            r_sync_err <= w_sof_abort || w_timeout;

            if (w_start || w_store) begin
                r_crc <= w_crc_stepped;
            end else if (w_check || w_timeout) begin
                r_crc <= INITIAL;
            end

            if (w_start) begin
                r_index <= 4'd1;
            end else if (w_store) begin
                r_index <= r_index + 4'd1;
            end else if (w_check || w_timeout) begin
                r_index <= 4'd0;
            end

            if (rx_valid || w_timeout || (r_state == S_IDLE)) begin
                r_tcnt <= 16'd0;
            end else begin
                r_tcnt <= r_tcnt + 16'd1;
            end

            if (w_match && (r_frame_count != 16'hFFFF)) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_any_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_lane
            logic [7:0] r_shadow_byte;
            logic [7:0] r_payload_byte;
            logic       w_load;

            assign w_load = (w_start && (gi == 0)) || (w_store && (r_index == 4'(gi)));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_shadow_byte  <= 8'd0;
                    r_payload_byte <= 8'd0;
                end else begin
                    if (w_load) begin
                        r_shadow_byte <= rx_data;
                    end
                    if (w_match) begin
                        r_payload_byte <= r_shadow_byte;
                    end
                end
            end

            assign payload_o[8*gi +: 8] = r_payload_byte;
        end
    endgenerate

    assign frame_ok    = r_frame_ok;
    assign crc_err     = r_crc_err;
    assign sync_err    = r_sync_err;
    assign busy        = (r_state != S_IDLE);
    assign frame_count = r_frame_count;
    assign err_count   = r_err_count;

    a_one_pulse: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({r_frame_ok, r_crc_err, r_sync_err}));

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Bench for crc8_frame_checker: three instances (default, one-byte payload, short-timeout
// saturation) checked every cycle against a frame-level queue model plus literal expectations.
module tb_crc8_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n = 3'b000;
    logic [2:0]  v = 3'b000;
    logic [2:0]  s = 3'b000;
    logic [7:0]  d [3];
    logic [2:0]  ok, ce, se, bz;
    logic [15:0] fc [3];
    logic [15:0] ec [3];
    logic [63:0] pay0;
    logic [7:0]  pay1;
    logic [15:0] pay2;

    int checks = 0;
    int failures = 0;

    crc8_frame_checker #(.PAYLOAD_BYTES(8)) dut0 (
        .clk(clk), .reset(rst_n[0]), .rx_valid(v[0]), .rx_sof(s[0]), .rx_data(d[0]),
        .payload_o(pay0), .frame_ok(ok[0]), .crc_err(ce[0]), .sync_err(se[0]), .busy(bz[0]),
        .frame_count(fc[0]), .err_count(ec[0]));

    crc8_frame_checker #(.PAYLOAD_BYTES(1)) dut1 (
        .clk(clk), .reset(rst_n[1]), .rx_valid(v[1]), .rx_sof(s[1]), .rx_data(d[1]),
        .payload_o(pay1), .frame_ok(ok[1]), .crc_err(ce[1]), .sync_err(se[1]), .busy(bz[1]),
        .frame_count(fc[1]), .err_count(ec[1]));

    crc8_frame_checker #(.PAYLOAD_BYTES(2), .TIMEOUT(16'd4)) dut2 (
        .clk(clk), .reset(rst_n[2]), .rx_valid(v[2]), .rx_sof(s[2]), .rx_data(d[2]),
        .payload_o(pay2), .frame_ok(ok[2]), .crc_err(ce[2]), .sync_err(se[2]), .busy(bz[2]),
        .frame_count(fc[2]), .err_count(ec[2]));

    function automatic int pb(input int k);
        case (k)
            0: return 8;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int tmo(input int k);
        return (k == 2) ? 4 : 1000;
    endfunction

    function automatic int sat(input int x);
        return (x >= 65535) ? 65535 : x + 1;
    endfunction

    // Bit-serial CRC-8 (poly 0x07, init 0xFF, MSB first).
    function automatic logic [7:0] crc8(input logic [7:0] b [16], input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ b[i][j];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    // Frame-level model: collected bytes per instance, idle cycles since last accepted byte.
    logic [7:0]   mbuf [3][16];
    logic [7:0]   tmp [16];
    int           mn [3];
    int           midle [3];
    int           e_fc [3];
    int           e_ec [3];
    logic [119:0] mpay [3];
    logic [2:0]   e_ok, e_ce, e_se;

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                e_ok[k] = 1'b0;
                e_ce[k] = 1'b0;
                e_se[k] = 1'b0;
                if (!rst_n[k]) begin
                    mn[k] = 0; midle[k] = 0; mpay[k] = '0; e_fc[k] = 0; e_ec[k] = 0;
                end else if (v[k]) begin
                    midle[k] = 0;
                    if (mn[k] == pb(k)) begin
                        for (int i = 0; i < 16; i++) tmp[i] = mbuf[k][i];
                        if (crc8(tmp, mn[k]) == d[k]) begin
                            e_ok[k] = 1'b1;
                            e_fc[k] = sat(e_fc[k]);
                            mpay[k] = '0;
                            for (int i = 0; i < pb(k); i++) mpay[k][8*i +: 8] = mbuf[k][i];
                        end else begin
                            e_ce[k] = 1'b1;
                            e_ec[k] = sat(e_ec[k]);
                        end
                        mn[k] = 0;
                    end else if (s[k]) begin
                        if (mn[k] != 0) begin
                            e_se[k] = 1'b1;
                            e_ec[k] = sat(e_ec[k]);
                        end
                        mbuf[k][0] = d[k];
                        mn[k] = 1;
                    end else if (mn[k] != 0) begin
                        mbuf[k][mn[k]] = d[k];
                        mn[k]++;
                    end
                end else if (mn[k] != 0) begin
                    midle[k]++;
                    if (midle[k] == tmo(k)) begin
                        e_se[k] = 1'b1;
                        e_ec[k] = sat(e_ec[k]);
                        mn[k] = 0;
                        midle[k] = 0;
                    end
                end
                if (k < 2 && (e_ok[k] || e_ce[k] || e_se[k]))
                    $display("txn inst=%0d t=%0t event=%s frames=%0d errors=%0d", k, $time,
                             e_ok[k] ? "frame_ok" : (e_ce[k] ? "crc_err" : "sync_err"), e_fc[k], e_ec[k]);
            end
        end
    end

    initial begin
        logic [127:0] act_pay;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0: act_pay = 128'(pay0);
                    1: act_pay = 128'(pay1);
                    default: act_pay = 128'(pay2);
                endcase
                chk("cmp_frame_ok", k, 128'(ok[k]), 128'(e_ok[k]));
                chk("cmp_crc_err", k, 128'(ce[k]), 128'(e_ce[k]));
                chk("cmp_sync_err", k, 128'(se[k]), 128'(e_se[k]));
                chk("cmp_busy", k, 128'(bz[k]), 128'(mn[k] != 0));
                chk("cmp_frame_count", k, 128'(fc[k]), 128'(e_fc[k]));
                chk("cmp_err_count", k, 128'(ec[k]), 128'(e_ec[k]));
                chk("cmp_payload", k, act_pay, 128'(mpay[k]));
            end
        end
    end

    task automatic send(input int k, input logic sof, input logic [7:0] dat);
        @(negedge clk);
        v[k] = 1'b1;
        s[k] = sof;
        d[k] = dat;
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            @(negedge clk);
            v[k] = 1'b0;
            s[k] = 1'b0;
        end
    endtask

    task automatic send_frame(input int k, input logic [7:0] b [16], input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            send(k, (i == 0), b[i]);
            if (maxgap > 0) idle(k, int'($urandom_range(0, maxgap)));
        end
        send(k, 1'b0, crc8(b, n));
    endtask

    task automatic pulse_reset(input int k);
        @(negedge clk);
        v[k] = 1'b0;
        s[k] = 1'b0;
        #1 rst_n[k] = 1'b0;
        @(negedge clk);
        rst_n[k] = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fa [16];
        logic [7:0] fb [16];
        int cnt;
        logic seen;
        for (int k = 0; k < 3; k++) d[k] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            fa[i] = 8'(i);
            fb[i] = 8'(8'h30 + i);
        end

        fork
            begin : inst0
                idle(0, 2);
                rst_n[0] = 1'b1;
                chk("reset_busy", 0, 128'(bz[0]), 128'd0);
                chk("reset_payload", 0, 128'(pay0), 128'd0);
                chk("reset_frame_count", 0, 128'(fc[0]), 128'd0);

                send_frame(0, fa, 8, 0);
                idle(0, 1);
                chk("t1_frame_ok", 0, 128'(ok[0]), 128'd1);
                chk("t1_payload", 0, 128'(pay0), 128'h0706050403020100);
                chk("t1_frame_count", 0, 128'(fc[0]), 128'd1);
                chk("t1_err_count", 0, 128'(ec[0]), 128'd0);

                pulse_reset(0);
                send(0, 1'b1, 8'hA0);
                send(0, 1'b0, 8'hA1);
                send(0, 1'b0, 8'hA2);
                send(0, 1'b0, 8'hA3);
                send(0, 1'b1, fb[0]);
                send(0, 1'b0, fb[1]);
                chk("t2_sync_err", 0, 128'(se[0]), 128'd1);
                for (int i = 2; i < 8; i++) send(0, 1'b0, fb[i]);
                send(0, 1'b0, crc8(fb, 8));
                idle(0, 1);
                chk("t2_frame_ok", 0, 128'(ok[0]), 128'd1);
                chk("t2_payload", 0, 128'(pay0), 128'h3736353433323130);
                chk("t2_frame_count", 0, 128'(fc[0]), 128'd1);
                chk("t2_err_count", 0, 128'(ec[0]), 128'd1);

                pulse_reset(0);
                send(0, 1'b1, 8'hC0);
                send(0, 1'b0, 8'hC1);
                send(0, 1'b0, 8'hC2);
                send(0, 1'b0, 8'hC3);
                idle(0, 1);
                cnt = 0;
                seen = 1'b0;
                while (cnt < 1020 && !seen) begin
                    @(negedge clk);
                    cnt++;
                    seen = se[0];
                end
                chk("t3_timeout_latency", 0, 128'(cnt), 128'd1000);
                chk("t3_busy_after", 0, 128'(bz[0]), 128'd0);
                chk("t3_err_count", 0, 128'(ec[0]), 128'd1);
                send_frame(0, fa, 8, 0);
                idle(0, 1);
                chk("t3_frame_ok", 0, 128'(ok[0]), 128'd1);
                chk("t3_frame_count", 0, 128'(fc[0]), 128'd1);

                pulse_reset(0);
                send_frame(0, fa, 8, 5);
                send_frame(0, fb, 8, 5);
                idle(0, 1);
                chk("t4_frame_ok", 0, 128'(ok[0]), 128'd1);
                chk("t4_frame_count", 0, 128'(fc[0]), 128'd2);
                chk("t4_err_count", 0, 128'(ec[0]), 128'd0);

                send(0, 1'b1, 8'hE0);
                send(0, 1'b0, 8'hE1);
                send(0, 1'b0, 8'hE2);
                idle(0, 1);
                chk("t5_busy_before", 0, 128'(bz[0]), 128'd1);
                #1 rst_n[0] = 1'b0;
                #1;
                chk("t5_rst_busy", 0, 128'(bz[0]), 128'd0);
                chk("t5_rst_frame_count", 0, 128'(fc[0]), 128'd0);
                chk("t5_rst_payload", 0, 128'(pay0), 128'd0);
                chk("t5_rst_pulses", 0, 128'({ok[0], ce[0], se[0]}), 128'd0);
                @(negedge clk);
                rst_n[0] = 1'b1;
                send_frame(0, fb, 8, 0);
                idle(0, 1);
                chk("t5_frame_ok", 0, 128'(ok[0]), 128'd1);
                chk("t5_frame_count", 0, 128'(fc[0]), 128'd1);
            end
            begin : inst1
                idle(1, 2);
                rst_n[1] = 1'b1;
                send(1, 1'b1, 8'h00);
                send(1, 1'b0, 8'hF3);
                send(1, 1'b1, 8'hFF);
                chk("pb1_ok_first", 1, 128'(ok[1]), 128'd1);
                send(1, 1'b0, 8'h00);
                send(1, 1'b1, 8'h00);
                chk("pb1_ok_second", 1, 128'(ok[1]), 128'd1);
                chk("pb1_payload_ff", 1, 128'(pay1), 128'hFF);
                send(1, 1'b0, 8'hF2);
                idle(1, 1);
                chk("pb1_crc_err", 1, 128'(ce[1]), 128'd1);
                chk("pb1_payload_kept", 1, 128'(pay1), 128'hFF);
                chk("pb1_err_count", 1, 128'(ec[1]), 128'd1);
                chk("pb1_frame_count", 1, 128'(fc[1]), 128'd2);
            end
            begin : inst2
                idle(2, 2);
                rst_n[2] = 1'b1;
                send(2, 1'b1, 8'hAA);
                for (int i = 0; i < 65540; i++) send(2, 1'b1, 8'(i));
                idle(2, 1);
                chk("sat_err_count", 2, 128'(ec[2]), 128'hFFFF);
                chk("sat_busy", 2, 128'(bz[2]), 128'd1);
                idle(2, 8);
                chk("sat_err_hold", 2, 128'(ec[2]), 128'hFFFF);
                chk("sat_busy_after", 2, 128'(bz[2]), 128'd0);
                chk("sat_frame_count", 2, 128'(fc[2]), 128'd0);
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc8_frame_checker.md
Name: crc8_frame_checker

Overview:
Receive-side companion of the CRC-8 stream inserter. Consumes a byte stream of frames: PAYLOAD_BYTES payload bytes followed by one CRC-8 byte (poly 0x07, init 0xFF, MSB-first, no reflection, no final XOR). Recomputes the CRC over the payload, compares it to the received CRC byte, and presents the payload with a pass/fail strobe to the trigger decode logic. Also maintains frame and error statistics, and aborts a frame on an inter-byte timeout.

Parameters:
PAYLOAD_BYTES, 8, number of payload bytes per frame (1..15).
POLYNOMIAL, 8'h07, CRC-8 generator polynomial.
INITIAL, 8'hFF, CRC register value at frame start.
TIMEOUT, 16'd1000, maximum clk cycles between accepted bytes inside a frame.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
rx_valid  in  1  rx_data is valid this cycle.
rx_sof  in  1  qualifies rx_data as the first payload byte; ignored unless rx_valid=1.
rx_data  in  8  received byte.
payload_o  out  8*PAYLOAD_BYTES  last good frame; byte 0 in bits [7:0].
frame_ok  out  1  one-cycle pulse: frame received and CRC matched.
crc_err  out  1  one-cycle pulse: CRC mismatch.
sync_err  out  1  one-cycle pulse: frame aborted by unexpected sof or timeout.
busy  out  1  high while in PAYLOAD or CRC state.
frame_count  out  16  good frames, saturating at 16'hFFFF.
err_count  out  16  crc_err plus sync_err events, saturating at 16'hFFFF.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; CRC register=INITIAL; byte index=0; timeout counter=0.
- A byte is accepted on a rising clk edge only when rx_valid=1.
- IDLE:
  - Accepted byte with rx_sof=1: store as payload byte 0, CRC := step(INITIAL, byte), index:=1, go to PAYLOAD. If PAYLOAD_BYTES=1, go to CRC instead.
  - Accepted byte with rx_sof=0: discard, no pulse.
- PAYLOAD:
  - Accepted byte with rx_sof=0: store at the current index, CRC := step(CRC, byte), index+1. When the last payload byte is stored, go to CRC.
  - Accepted byte with rx_sof=1: sync_err pulse, then restart the frame with this byte as byte 0, same handling as in IDLE.
- CRC:
  - Accepted byte is compared to the CRC register (rx_sof is ignored).
  - Match: copy the shadow payload to payload_o; frame_ok pulses the next cycle.
  - Mismatch: payload_o is unchanged; crc_err pulses the next cycle.
  - Either way: return to IDLE and reload the CRC register with INITIAL.
- step(c, d): x = c XOR d, then 8 iterations of x = x[7] ? (x<<1) XOR POLYNOMIAL : (x<<1). Combinational, one byte per cycle, no throughput stall.
- Payload buffering: bytes are collected in a shadow register; payload_o updates only on a good frame and stays stable otherwise.
- Timeout: in PAYLOAD or CRC, the counter increments each cycle without an accepted byte and clears on any accepted byte. On reaching TIMEOUT: sync_err pulse, go to IDLE, reload CRC. In IDLE the counter is held at 0.
- Pulse latency: frame_ok, crc_err and sync_err are registered and assert 1 cycle after the deciding edge. At most one of them is high in any cycle.
- Counters:
  - frame_count increments with frame_ok.
  - err_count increments with crc_err or sync_err.
  - Both saturate at 16'hFFFF and never wrap.
- Back-to-back frames: a sof byte in the cycle immediately after the CRC byte is accepted (state is already IDLE).
- busy = (state != IDLE).

Test Plan:
- Default params, payload 00..07 followed by the bench-model CRC, rx_valid held high -> frame_ok pulses 1 cycle after the CRC byte; payload_o = 64'h0706050403020100; frame_count=1; err_count=0.
- PAYLOAD_BYTES=1: frame {0x00 sof, 0xF3} -> frame_ok; frame {0xFF sof, 0x00} -> frame_ok; frame {0x00 sof, 0xF2} -> crc_err, payload_o stays 8'hFF, err_count=1.
- sof reasserted at byte 4 of a frame, followed by a complete valid frame -> sync_err on the abort, then frame_ok; frame_count=1; err_count=1.
- rx_valid dropped for TIMEOUT cycles after byte 3 -> sync_err exactly TIMEOUT cycles after the last accepted byte; busy returns to 0; a following valid frame passes.
- Two valid frames back-to-back with no idle cycle, and random rx_valid gaps shorter than TIMEOUT -> two frame_ok pulses; frame_count=2.
- Reset asserted mid-frame -> all outputs 0 immediately; a subsequent valid frame passes; counters preset near 16'hFFFF saturate and do not wrap.
